// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state encoding, ASCII constants and nibble encode helper
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HEX_HI = 2'b01,
    HEX_LO = 2'b10,
    RESP   = 2'b11
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_L  = 8'h4C;

  localparam int unsigned REPLY_DEPTH = 4;

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_cmd_parser_hex_ascii.sv
// rtl/uart_cmd_parser_hex_ascii.sv - byte to two uppercase ASCII hex chars, ASCII hex char to nibble
module hex_ascii
  import uart_cmd_pkg::*;
(
  input  logic [7:0] val_i,
  output logic [7:0] asc_hi_o,
  output logic [7:0] asc_lo_o,
  input  logic [7:0] asc_i,
  output logic [3:0] nib_o,
  output logic       nib_valid_o
);

  assign asc_hi_o = nib2asc(val_i[7:4]);
  assign asc_lo_o = nib2asc(val_i[3:0]);

  // 'A'..'F' and 'a'..'f' share low nibbles 1..6, so +9 maps both to 10..15
  always_comb begin
    nib_o       = 4'h0;
    nib_valid_o = 1'b0;
    if (asc_i >= 8'h30 && asc_i <= 8'h39) begin
      nib_o       = asc_i[3:0];
      nib_valid_o = 1'b1;
    end else if ((asc_i >= 8'h41 && asc_i <= 8'h46) || (asc_i >= 8'h61 && asc_i <= 8'h66)) begin
      nib_o       = asc_i[3:0] + 4'd9;
      nib_valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII command parser (S/B/Lxx) with reply stream and inter-byte timeout
// Optional byte echo: define UART_CMD_ECHO_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic [7:0] sw,
  input  logic [4:0] btn,
  output logic [7:0] led,
  output logic       err
);

  state_e                         state_q, state_d;
  logic [REPLY_DEPTH-1:0][7:0]    buf_q, buf_d;
  logic [2:0]                     len_q, len_d;
  logic [1:0]                     idx_q, idx_d;
  logic [3:0]                     hi_q, hi_d;
  logic [7:0]                     led_q, led_d;
  logic                           err_q, err_d;
  logic [31:0]                    tmo_q, tmo_d;

  logic [7:0] sample, asc_hi, asc_lo;
  logic [3:0] nib;
  logic       nib_valid;
  logic       rx_ok;
  logic       reply_xfer;

  assign sample = (rx_data == ASCII_B) ? {3'b000, btn} : sw;

  hex_ascii u_hex (
    .val_i      (sample),
    .asc_hi_o   (asc_hi),
    .asc_lo_o   (asc_lo),
    .asc_i      (rx_data),
    .nib_o      (nib),
    .nib_valid_o(nib_valid)
  );

`ifdef UART_CMD_ECHO_EN
  logic       echo_full_q, echo_full_d;
  logic [7:0] echo_q, echo_d;

  assign rx_ok      = !echo_full_q;
  assign reply_xfer = (state_q == RESP) && tx_ready && !echo_full_q;
  assign tx_valid   = echo_full_q || (state_q == RESP);
  assign tx_data    = echo_full_q ? echo_q : ((state_q == RESP) ? buf_q[idx_q] : 8'h00);

  always_comb begin
    echo_full_d = echo_full_q;
    echo_d      = echo_q;
    if (echo_full_q && tx_ready) echo_full_d = 1'b0;
    if (rx_valid && rx_ok && state_q != RESP) begin
      echo_full_d = 1'b1;
      echo_d      = rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_full_q <= 1'b0;
      echo_q      <= 8'h00;
    end else begin
      echo_full_q <= echo_full_d;
      echo_q      <= echo_d;
    end
  end
`else
  assign rx_ok      = 1'b1;
  assign reply_xfer = (state_q == RESP) && tx_ready;
  assign tx_valid   = (state_q == RESP);
  assign tx_data    = (state_q == RESP) ? buf_q[idx_q] : 8'h00;
`endif

  assign led = led_q;
  assign err = err_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    led_d   = led_q;
    err_d   = 1'b0;
    tmo_d   = 32'd0;
    case (state_q)
      IDLE: begin
        if (rx_valid && !rx_ok) begin
          err_d = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == ASCII_S || rx_data == ASCII_B) begin
            buf_d   = {ASCII_LF, ASCII_CR, asc_lo, asc_hi};
            len_d   = 3'd4;
            idx_d   = 2'd0;
            state_d = RESP;
          end else if (rx_data == ASCII_L) begin
            state_d = HEX_HI;
          end else if (rx_data != ASCII_CR && rx_data != ASCII_LF && rx_data != ASCII_SP) begin
            buf_d   = {8'h00, ASCII_LF, ASCII_CR, ASCII_Q};
            len_d   = 3'd3;
            idx_d   = 2'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      HEX_HI, HEX_LO: begin
        tmo_d = tmo_q + 32'd1;
        if (rx_valid && !rx_ok) err_d = 1'b1;
        if (rx_valid && rx_ok) begin
          tmo_d = 32'd0;
          if (!nib_valid) begin
            buf_d   = {8'h00, ASCII_LF, ASCII_CR, ASCII_Q};
            len_d   = 3'd3;
            idx_d   = 2'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (state_q == HEX_HI) begin
            hi_d    = nib;
            state_d = HEX_LO;
          end else begin
            led_d   = {hi_q, nib};
            buf_d   = {8'h00, ASCII_LF, ASCII_CR, ASCII_K};
            len_d   = 3'd3;
            idx_d   = 2'd0;
            state_d = RESP;
          end
        end else if (tmo_q == TIMEOUT_CLKS - 1) begin
          tmo_d   = 32'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (rx_valid) err_d = 1'b1;
        if (reply_xfer) begin
          if ({1'b0, idx_q} + 3'd1 == len_q) state_d = IDLE;
          else idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      len_q   <= 3'd0;
      idx_q   <= 2'd0;
      hi_q    <= 4'h0;
      led_q   <= 8'h00;
      err_q   <= 1'b0;
      tmo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      led_q   <= led_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
